// File: rtl/popcount_accum_pkg.sv
// Shared types and default sizing for the popcount frame accumulator.
// Defaults: 16 words of 64 bits per frame, so the total fits in 11 bits.
package popcount_accum_pkg;
   localparam int WORD_BITS     = 64;
   localparam int MAX_WORDS_DEF = 16;
   localparam int ACC_W_DEF     = 11;
   localparam int CNT_W_DEF     = 5;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;
endpackage

// File: rtl/popcount_sat_add.sv
// One-beat update: clamp the count to 64, add it, and saturate the word count.
// Beats past MAX_WORDS leave the sum untouched and raise the overflow flag.
module popcount_sat_add
   import popcount_accum_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [CNT_W-1:0] wcnt_i,
   input  logic             ovf_i,
   input  logic             err_i,
   input  logic [6:0]       cnt_i,
   output logic [ACC_W-1:0] acc_o,
   output logic [CNT_W-1:0] wcnt_o,
   output logic             ovf_o,
   output logic             err_o
);

   logic       big;
   logic       full;
   logic [6:0] clamp;

   assign big   = cnt_i > 7'(WORD_BITS);
   assign clamp = big ? 7'(WORD_BITS) : cnt_i;
   assign full  = wcnt_i >= CNT_W'(MAX_WORDS);

   always_comb begin
      acc_o  = acc_i;
      wcnt_o = wcnt_i;
      if (!full) begin
         acc_o  = acc_i + ACC_W'(clamp);
         wcnt_o = wcnt_i + CNT_W'(1);
      end
      ovf_o = ovf_i | full;
      err_o = err_i | big;
   end

endmodule

// File: rtl/popcount_accum.sv
// Frame accumulator: sums per-word popcounts and presents one held result
// per frame; a new frame may start in the same cycle the result is taken.
module popcount_accum
   import popcount_accum_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       cnt_in,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic [ACC_W-1:0] thresh,
   output logic [ACC_W-1:0] sum_out,
   output logic [CNT_W-1:0] words_out,
   output logic             above_thr,
   output logic             ovf,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic               fovf_q, fovf_d;
   logic               ferr_q, ferr_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               above_q, above_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic               accept;
   logic [ACC_W-1:0]   add_acc;
   logic [CNT_W-1:0]   add_wcnt;
   logic               add_ovf;
   logic               add_err;

   assign in_ready = !rst && ((state_q == ACC) || out_ready);
   assign accept   = in_valid && in_ready;

   popcount_sat_add #(
      .MAX_WORDS (MAX_WORDS),
      .ACC_W     (ACC_W),
      .CNT_W     (CNT_W)
   ) u_add (
      .acc_i  (acc_q),
      .wcnt_i (wcnt_q),
      .ovf_i  (fovf_q),
      .err_i  (ferr_q),
      .cnt_i  (cnt_in),
      .acc_o  (add_acc),
      .wcnt_o (add_wcnt),
      .ovf_o  (add_ovf),
      .err_o  (add_err)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      wcnt_d  = wcnt_q;
      fovf_d  = fovf_q;
      ferr_d  = ferr_q;
      sum_d   = sum_q;
      words_d = words_q;
      above_d = above_q;
      ovf_d   = ovf_q;
      err_d   = err_q;

      unique case (state_q)
         ACC:  state_d = ACC;
         HOLD: if (out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase

      // In HOLD the frame registers are already clear, so an accepted
      // beat there naturally opens the next frame.
      if (accept) begin
         if (in_last) begin
            sum_d   = add_acc;
            words_d = add_wcnt;
            above_d = add_acc >= thresh;
            ovf_d   = add_ovf;
            err_d   = add_err;
            acc_d   = '0;
            wcnt_d  = '0;
            fovf_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = HOLD;
         end else begin
            acc_d   = add_acc;
            wcnt_d  = add_wcnt;
            fovf_d  = add_ovf;
            ferr_d  = add_err;
            state_d = ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         wcnt_q  <= '0;
         fovf_q  <= 1'b0;
         ferr_q  <= 1'b0;
         sum_q   <= '0;
         words_q <= '0;
         above_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         wcnt_q  <= wcnt_d;
         fovf_q  <= fovf_d;
         ferr_q  <= ferr_d;
         sum_q   <= sum_d;
         words_q <= words_d;
         above_q <= above_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = state_q == HOLD;
   assign sum_out   = sum_q;
   assign words_out = words_q;
   assign above_thr = above_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed and randomized frames for popcount_accum, checked against
// a frame-level model of the summing rules.
module tb_popcount_accum;

   localparam int MW = 16;
   localparam int AW = 11;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    cnt_in = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [AW-1:0] thresh = '0;
   logic [AW-1:0] sum_out;
   logic [CW-1:0] words_out;
   logic          above_thr;
   logic          ovf;
   logic          err;
   logic          out_valid;
   logic          out_ready = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   popcount_accum #(.MAX_WORDS(MW), .ACC_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_in    (cnt_in),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .thresh    (thresh),
      .sum_out   (sum_out),
      .words_out (words_out),
      .above_thr (above_thr),
      .ovf       (ovf),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int c, input bit last);
      in_valid = 1'b1;
      cnt_in   = 7'(c);
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_res(input string tag, input int s, input int w,
                            input int a, input int o, input int e);
      check({tag, ".valid"}, 32'(out_valid), 1);
      check({tag, ".sum"},   32'(sum_out),   s);
      check({tag, ".words"}, 32'(words_out), w);
      check({tag, ".above"}, 32'(above_thr), a);
      check({tag, ".ovf"},   32'(ovf),       o);
      check({tag, ".err"},   32'(err),       e);
   endtask

   // Frame total: only the first MW words count, each worth at most 64.
   task automatic model(input int q[$], input int th, output int s,
                        output int w, output int a, output int o,
                        output int e);
      s = 0;
      e = 0;
      foreach (q[i]) begin
         if (i < MW) s += (q[i] > 64) ? 64 : q[i];
         if (q[i] > 64) e = 1;
      end
      w = (q.size() > MW) ? MW : q.size();
      o = (q.size() > MW) ? 1 : 0;
      a = (s >= th) ? 1 : 0;
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      int s, w, a, o, e, n, th, k;

      // reset
      tick();
      check("rst.in_ready", 32'(in_ready), 0);
      tick();
      check("rst.out_valid", 32'(out_valid), 0);
      check("rst.sum", 32'(sum_out), 0);
      check("rst.words", 32'(words_out), 0);
      check("rst.flags", 32'({above_thr, ovf, err}), 0);
      rst = 1'b0;
      #1;
      check("idle.in_ready", 32'(in_ready), 1);

      // four-beat frame
      out_ready = 1'b1;
      thresh    = 11'd100;
      beat(64, 0);
      beat(0, 0);
      beat(33, 0);
      check("f4.no_early", 32'(out_valid), 0);
      beat(7, 1);
      check_res("f4", 104, 4, 1, 0, 0);
      tick();
      check("f4.drain", 32'(out_valid), 0);

      // held result with back-pressure
      out_ready = 1'b0;
      beat(10, 1);
      in_valid = 1'b1;
      cnt_in   = 7'd20;
      in_last  = 1'b1;
      thresh   = 11'd15;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold.in_ready", 32'(in_ready), 0);
         check_res("hold", 10, 1, 0, 0, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("rel.in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_res("rel", 20, 1, 1, 0, 0);
      tick();
      check("rel.drain", 32'(out_valid), 0);

      // back-to-back single-word frames
      thresh   = 11'd2;
      in_valid = 1'b1;
      in_last  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cnt_in = 7'(i);
         tick();
         check_res("b2b", i, 1, (i >= 2) ? 1 : 0, 0, 0);
         check("b2b.in_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      check("b2b.drain", 32'(out_valid), 0);

      // overflow past MAX_WORDS
      thresh = 11'd1024;
      for (int i = 0; i < 18; i++) beat(64, i == 17);
      check_res("ovf", 1024, 16, 1, 1, 0);
      tick();

      // out-of-range count, then clean frame
      thresh = 11'd70;
      beat(100, 0);
      beat(5, 1);
      check_res("err", 69, 2, 0, 0, 1);
      tick();
      beat(5, 1);
      check_res("noerr", 5, 1, 0, 0, 0);
      tick();

      // reset mid-frame
      beat(5, 0);
      beat(6, 0);
      beat(7, 0);
      rst = 1'b1;
      #1;
      check("mid.in_ready", 32'(in_ready), 0);
      tick();
      rst = 1'b0;
      check("mid.out_valid", 32'(out_valid), 0);
      check("mid.sum", 32'(sum_out), 0);
      tick();
      check("mid.idle", 32'(out_valid), 0);
      thresh = 11'd9;
      beat(9, 1);
      check_res("mid", 9, 1, 1, 0, 0);
      tick();

      // randomized frames with idle gaps and stalls
      for (int f = 0; f < 25; f++) begin
         q.delete();
         n  = int'($urandom_range(1, 20));
         th = int'($urandom_range(0, 1100));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) q.push_back(int'($urandom_range(65, 127)));
            else q.push_back(int'($urandom_range(0, 64)));
         end
         thresh    = 11'(th);
         out_ready = 1'b1;
         foreach (q[i]) begin
            k = int'($urandom_range(0, 2));
            for (int g = 0; g < k; g++) begin
               cnt_in = 7'($urandom_range(0, 127));
               tick();
            end
            beat(q[i], i == n - 1);
         end
         thresh = 11'($urandom_range(0, 2047));
         model(q, th, s, w, a, o, e);
         check_res("rnd", s, w, a, o, e);
         k = int'($urandom_range(0, 3));
         out_ready = 1'b0;
         for (int g = 0; g < k; g++) begin
            tick();
            check_res("rnd.stall", s, w, a, o, e);
         end
         out_ready = 1'b1;
         tick();
         check("rnd.drain", 32'(out_valid), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
